ternary_plus: RTL and testbench

//  Downstream stage of the ternary sampler in the NTRU-HRSS key-generation path (sample_iid_plus).

---
 rtl/ntru_hrss_pkg.sv | 31 +++
 rtl/tern_pair_prod.sv | 25 ++
 rtl/ternary_plus.sv | 141 ++++++++++++++
 tb/tb_ternary_plus.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ntru_hrss_pkg.sv
// Shared constants, ternary codes and FSM state type for the
// NTRU-HRSS key-generation ternary sampling path.
package ntru_hrss_pkg;

   localparam int N_COEF   = 700;
   localparam int TP_LANES = 4;
   localparam int TP_ACC_W = 11;

   typedef logic [1:0] tern_t;

   localparam tern_t TERN_ZERO = 2'b00;
   localparam tern_t TERN_POS  = 2'b01;
   localparam tern_t TERN_NEG  = 2'b10;
   localparam tern_t TERN_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      CORR,
      FLIP
   } tp_state_t;

   // 00 and 11 are left as they are.
   function automatic tern_t tern_neg(input tern_t c);
      tern_t r;
      r = c;
      if (c == TERN_POS) r = TERN_NEG;
      if (c == TERN_NEG) r = TERN_POS;
      return r;
   endfunction

endpackage

// File: rtl/tern_pair_prod.sv
// Product of two ternary codes in {-1,0,+1}; an illegal code
// contributes 0 and raises ill.
module tern_pair_prod
   import ntru_hrss_pkg::*;
(
   input  tern_t             a,
   input  tern_t             b,
   output logic signed [1:0] prod,
   output logic              ill
);

   logic a_nz;
   logic b_nz;

   always_comb begin
      prod = 2'sb00;
      ill  = (a == TERN_ILL) || (b == TERN_ILL);
      a_nz = (a == TERN_POS) || (a == TERN_NEG);
      b_nz = (b == TERN_POS) || (b == TERN_NEG);
      if (a_nz && b_nz) begin
         prod = (a == b) ? 2'sb01 : 2'sb11;
      end
   end

endmodule

// File: rtl/ternary_plus.sv
// Correlation sign of a packed ternary vector; negates even
// coefficients when sum v_i*v_{i+1} is negative.
module ternary_plus
   import ntru_hrss_pkg::*;
#(
   parameter int N_COEF = ntru_hrss_pkg::N_COEF,
   parameter int LANES  = ntru_hrss_pkg::TP_LANES,
   parameter int ACC_W  = ntru_hrss_pkg::TP_ACC_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2*N_COEF-1:0] in_vec,
   output logic [2*N_COEF-1:0] out_vec,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int NGRP  = N_COEF / LANES;
   localparam int CNT_W = $clog2(NGRP);
   localparam int SUM_W = $clog2(LANES + 1) + 1;
   localparam int VEC_W = 2 * N_COEF;

   tp_state_t state_q, state_d;
   logic [VEC_W-1:0] shreg_q, shreg_d;
   logic [VEC_W-1:0] hold_q, hold_d;
   logic [VEC_W-1:0] out_q, out_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   tern_t            prev_q, prev_d;
   logic             err_q, err_d;
   logic             done_q, done_d;

   tern_t             lane [LANES];
   logic signed [1:0] prod [LANES];
   logic [LANES-1:0]  ill;
   logic [SUM_W-1:0]  grp_sum;

   // Lane 0 links to the last coefficient of the previous group.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane[g] = shreg_q[2*g +: 2];
      if (g == 0) begin : g_link
         tern_pair_prod u_pp (
            .a    (prev_q),
            .b    (lane[0]),
            .prod (prod[0]),
            .ill  (ill[0])
         );
      end else begin : g_in
         tern_pair_prod u_pp (
            .a    (lane[g-1]),
            .b    (lane[g]),
            .prod (prod[g]),
            .ill  (ill[g])
         );
      end
   end

   always_comb begin
      grp_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         grp_sum = grp_sum + {{(SUM_W-2){prod[i][1]}}, prod[i]};
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      hold_d  = hold_q;
      out_d   = out_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      prev_d  = prev_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CORR;
               shreg_d = in_vec;
               hold_d  = in_vec;
               acc_d   = '0;
               cnt_d   = '0;
               prev_d  = TERN_ZERO;
               err_d   = 1'b0;
            end
         end
         CORR: begin
            acc_d   = acc_q
                    + {{(ACC_W-SUM_W){grp_sum[SUM_W-1]}}, grp_sum};
            prev_d  = lane[LANES-1];
            shreg_d = shreg_q >> (2*LANES);
            cnt_d   = cnt_q + 1'b1;
            err_d   = err_q | (|ill);
            if (cnt_q == CNT_W'(NGRP-1)) state_d = FLIP;
         end
         FLIP: begin
            out_d = hold_q;
            for (int i = 0; i < N_COEF; i += 2) begin
               if (acc_q[ACC_W-1]) begin
                  out_d[2*i +: 2] = tern_neg(hold_q[2*i +: 2]);
               end
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         hold_q  <= '0;
         out_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         prev_q  <= TERN_ZERO;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         hold_q  <= hold_d;
         out_q   <= out_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         prev_q  <= prev_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign out_vec = out_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_ternary_plus.sv
// Directed and random runs of ternary_plus against a coefficient-level
// model of the correlation sign and even-coefficient flip.
module tb_ternary_plus;

   localparam int N   = 700;
   localparam int W   = 2 * N;
   localparam int LAT = 176;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] in_vec;
   logic [W-1:0] out_vec;
   logic         busy;
   logic         done;
   logic         err;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   ternary_plus u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .in_vec  (in_vec),
      .out_vec (out_vec),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   function automatic int cval(input logic [1:0] c);
      if (c == 2'b01) return 1;
      if (c == 2'b10) return -1;
      return 0;
   endfunction

   function automatic logic [W-1:0] model(input logic [W-1:0] v,
                                          output bit e);
      logic [W-1:0] r;
      logic [1:0]   c;
      int           t;
      t = 0;
      e = 1'b0;
      for (int i = 0; i < N; i++)
         if (v[2*i +: 2] == 2'b11) e = 1'b1;
      for (int i = 0; i < N - 1; i++)
         t += cval(v[2*i +: 2]) * cval(v[2*i+2 +: 2]);
      r = v;
      if (t < 0) begin
         for (int i = 0; i < N; i += 2) begin
            c = v[2*i +: 2];
            if (c == 2'b01) r[2*i +: 2] = 2'b10;
            if (c == 2'b10) r[2*i +: 2] = 2'b01;
         end
      end
      return r;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_vec(input string tag, input logic [W-1:0] obs,
                          input logic [W-1:0] exp);
      int k;
      k = -1;
      for (int i = N - 1; i >= 0; i--)
         if (obs[2*i +: 2] !== exp[2*i +: 2]) k = i;
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: coef %0d observed %b expected %b",
                  tag, k, obs[2*k +: 2], exp[2*k +: 2]);
   endtask

   function automatic logic [W-1:0] rand_vec(input bit allow_ill);
      logic [W-1:0] v;
      for (int i = 0; i < N; i++) begin
         v[2*i +: 2] = 2'($urandom_range(0, 2));
         if (allow_ill && $urandom_range(0, 99) == 0) v[2*i +: 2] = 2'b11;
      end
      return v;
   endfunction

   task automatic run(input string tag, input logic [W-1:0] v,
                      input bit poke);
      logic [W-1:0] exp;
      bit           e;
      int           n;
      bit           seen;
      exp = model(v, e);
      @(negedge clk);
      in_vec = v;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      in_vec = ~v;
      chk({tag, " busy"}, int'(busy), 1);
      n    = 0;
      seen = 1'b0;
      while (n < 400 && !seen) begin
         @(negedge clk);
         n++;
         start = poke && (n == 50);
         seen  = done;
      end
      start = 1'b0;
      chk({tag, " latency"}, n, LAT);
      chk_vec({tag, " out"}, out_vec, exp);
      chk({tag, " err"}, int'(err), int'(e));
      @(negedge clk);
      chk({tag, " done pulse"}, int'(done), 0);
   endtask

   initial begin : stim
      logic [W-1:0] v;
      logic [W-1:0] x;
      int           seen;
      rst    = 1'b1;
      start  = 1'b0;
      in_vec = '0;
      #12;
      chk("reset out", int'(out_vec != '0), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset err", int'(err), 0);
      @(negedge clk);
      rst = 1'b0;

      run("zeros", '0, 1'b0);

      for (int i = 0; i < N; i++) v[2*i +: 2] = 2'b01;
      run("all_pos", v, 1'b0);
      chk_vec("all_pos const", out_vec, v);

      for (int i = 0; i < N; i++) v[2*i +: 2] = i[0] ? 2'b10 : 2'b01;
      for (int i = 0; i < N; i++) x[2*i +: 2] = 2'b10;
      run("alt", v, 1'b0);
      chk_vec("alt const", out_vec, x);

      v = '0;
      v[3:0] = 4'b1001;
      x = '0;
      x[3:0] = 4'b1010;
      run("pair_a", v, 1'b0);
      chk_vec("pair_a const", out_vec, x);
      v[3:0] = 4'b0110;
      run("pair_b", v, 1'b0);
      x[3:0] = 4'b0101;
      chk_vec("pair_b const", out_vec, x);

      v = '0;
      v[W-1 -: 2] = 2'b11;
      run("ill_last", v, 1'b0);
      chk("ill_last err1", int'(err), 1);

      for (int r = 0; r < 6; r++) run("rand", rand_vec(r >= 4), r == 2);

      for (int i = 0; i < N; i++) v[2*i +: 2] = i[0] ? 2'b10 : 2'b01;
      @(negedge clk);
      in_vec = rand_vec(1'b0);
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n < 90; n++) begin
         @(negedge clk);
         if (n == 50) begin
            start  = 1'b1;
            in_vec = v;
         end else start = 1'b0;
      end
      start = 1'b0;
      rst   = 1'b1;
      #1;
      chk("abort out", int'(out_vec != '0), 0);
      chk("abort busy", int'(busy), 0);
      chk("abort done", int'(done), 0);
      chk("abort err", int'(err), 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("abort no done", seen, 0);
      run("restart", v, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
